// File: rtl/pixel_pkg.sv
// pixel_pkg: shared frame geometry defaults, scheduler state encoding and batch derivation
package pixel_pkg;
    localparam int DEF_NUM_PIXELS = 8;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;
    typedef enum logic [2:0] {
        IDLE,
        NEW_FRAME,
        COMPUTE,
        PUSH,
        PUSH_LAST,
        DONE
    } state_e;
    function automatic int batches(input int h_res, input int v_res, input int num_pixels);
        return h_res * v_res / num_pixels;
    endfunction
endpackage

// File: rtl/batch_scheduler.sv
// batch_scheduler: sequences one pixel_processor through a frame and pushes each batch result downstream
module batch_scheduler
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   frame_start,
    input  logic                   result_ready,
    input  logic                   fifo_full,
    output logic                   new_frame,
    output logic                   start_next_batch,
    output logic                   fifo_push,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_overrun,
    output logic [COUNT_WIDTH-1:0] batch_count
);
    localparam int BATCHES = batches(H_RES, V_RES, NUM_PIXELS);
    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(BATCHES - 1);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overrun_q, overrun_d;

    // Next state and batch counter; a frame_start while busy restarts the frame from any state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        overrun_d = frame_start && state_q != IDLE && state_q != DONE;
        case (state_q)
            IDLE:      state_d = (frame_start && enable) ? NEW_FRAME : IDLE;
            NEW_FRAME: begin
                count_d = '0;
                state_d = COMPUTE;
            end
            COMPUTE:   state_d = (result_ready && !fifo_full) ? ((count_q == LAST) ? PUSH_LAST : PUSH) : COMPUTE;
            PUSH:      begin
                count_d = count_q + 1'b1;
                state_d = COMPUTE;
            end
            PUSH_LAST: begin
                count_d = count_q + 1'b1;
                state_d = DONE;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (frame_start && state_q != IDLE) state_d = NEW_FRAME;
    end

    // State, counter and overrun pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign new_frame = state_q == NEW_FRAME;
    assign start_next_batch = state_q == PUSH;
    assign fifo_push = state_q == PUSH || state_q == PUSH_LAST;
    assign busy = state_q != IDLE;
    assign frame_done = state_q == DONE;
    assign frame_overrun = overrun_q;
    assign batch_count = count_q;
endmodule

// File: tb/tb_batch_scheduler.sv
// tb_batch_scheduler: scoreboard bench with a stub pixel_processor on an 8-batch frame
module tb_batch_scheduler;
    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int snb;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        frame_start = 1'b0;
    logic        result_ready;
    logic        fifo_full = 1'b0;
    logic        new_frame, start_next_batch, fifo_push, busy, frame_done, frame_overrun;
    logic [15:0] batch_count;
    int          cyc = 0;
    int          pc = 15;
    int          checks = 0;
    int          passed = 0;
    ev_t         exp_q[$];

    batch_scheduler #(
        .NUM_PIXELS(8),
        .H_RES(32),
        .V_RES(2),
        .COUNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .frame_start(frame_start),
        .result_ready(result_ready),
        .fifo_full(fifo_full),
        .new_frame(new_frame),
        .start_next_batch(start_next_batch),
        .fifo_push(fifo_push),
        .busy(busy),
        .frame_done(frame_done),
        .frame_overrun(frame_overrun),
        .batch_count(batch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) pc <= (new_frame || start_next_batch) ? 0 : (pc == 15 ? 15 : pc + 1);

    assign result_ready = pc == 15;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_event_kind%0d", kind), 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk($sformatf("event_cycle_kind%0d", kind), cyc, e.cyc);
            if (e.cnt >= 0) chk($sformatf("batch_count_kind%0d", kind), int'(batch_count), e.cnt);
            if (kind == 1) chk("start_next_batch_on_push", int'(start_next_batch), e.snb);
        end
    endtask

    // Monitor: in-cycle order is overrun, new_frame, push, done
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_overrun) pop_cmp(3);
            if (new_frame) pop_cmp(0);
            if (fifo_push) pop_cmp(1);
            if (frame_done) pop_cmp(2);
            if (start_next_batch && !fifo_push) chk("stray_start_next_batch", 1, 0);
        end
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic pulse_fs(output int c);
        frame_start = 1'b1;
        c = cyc;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic exp_frame(input int c, input int nf_cnt, input int npush, input int stall_at, input int stall_len);
        int cy;
        exp_q.push_back('{0, c + 1, nf_cnt, 0});
        cy = 0;
        for (int i = 0; i < npush; i++) begin
            cy = c + 1 + 17 * (i + 1) + (i >= stall_at ? stall_len : 0);
            exp_q.push_back('{1, cy, i, (i < 7) ? 1 : 0});
        end
        if (npush == 8) exp_q.push_back('{2, cy + 1, 8, 0});
    endtask

    initial begin
        int c;
        int x;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_new_frame", int'(new_frame), 0);
        chk("reset_batch_count", int'(batch_count), 0);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_fs(c);
        exp_frame(c, 0, 8, 99, 0);
        wait_cyc(c + 1 + 136 + 1 + 3);
        chk("frame1_final_count", int'(batch_count), 8);
        chk("frame1_idle", int'(busy), 0);
        pulse_fs(c);
        exp_frame(c, 8, 8, 3, 20);
        wait_cyc(c + 68);
        fifo_full = 1'b1;
        wait_cyc(c + 88);
        fifo_full = 1'b0;
        wait_cyc(c + 1 + 136 + 1 + 20 + 3);
        chk("stall_final_count", int'(batch_count), 8);
        pulse_fs(c);
        exp_frame(c, 8, 5, 99, 0);
        wait_cyc(c + 90);
        exp_q.push_back('{3, c + 91, -1, 0});
        pulse_fs(x);
        exp_frame(x, 5, 8, 99, 0);
        wait_cyc(x + 1 + 136 + 1 + 3);
        chk("overrun_final_count", int'(batch_count), 8);
        pulse_fs(c);
        exp_frame(c, 8, 2, 99, 0);
        wait_cyc(c + 40);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_push", int'(fifo_push), 0);
        chk("async_reset_snb", int'(start_next_batch), 0);
        chk("async_reset_count", int'(batch_count), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_fs(c);
        exp_frame(c, 0, 8, 99, 0);
        wait_cyc(c + 1 + 136 + 1 + 3);
        chk("post_reset_final_count", int'(batch_count), 8);
        enable = 1'b0;
        pulse_fs(c);
        repeat (5) @(negedge clk);
        chk("disabled_busy", int'(busy), 0);
        enable = 1'b1;
        pulse_fs(c);
        exp_frame(c, 8, 8, 99, 0);
        wait_cyc(c + 30);
        enable = 1'b0;
        wait_cyc(c + 1 + 136 + 1 + 3);
        enable = 1'b1;
        chk("enable_drop_final_count", int'(batch_count), 8);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
